// File: rtl/enemy_ai_ctrl.sv
// enemy_ai_ctrl: frame-rate enemy behaviour controller.
// Picks chase / retreat / shoot / dodge / guard from player distance, good-bullet
// threat, an attack cooldown and a random tie-break bit. Commands are registered
// and change only on frame ticks. Dropping i_enable forces a return to idle.
module enemy_ai_ctrl #(
    parameter int unsigned NEAR_DIST    = 160,
    parameter int unsigned FAR_DIST     = 320,
    parameter int unsigned DODGE_DIST   = 96,
    parameter int unsigned ATK_COOLDOWN = 30,
    parameter int unsigned DODGE_FRAMES = 8,
    parameter int unsigned GUARD_FRAMES = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_enable,
    input  logic               i_tick,
    input  logic signed [10:0] i_player_x,
    input  logic               i_player_squat,
    input  logic signed [10:0] i_enemy_x,
    input  logic               i_gb_active,
    input  logic signed [10:0] i_gb_x,
    input  logic               i_bb_busy,
    input  logic [3:0]         i_rnd,
    output logic               o_right,
    output logic               o_left,
    output logic               o_jump,
    output logic               o_squat,
    output logic               o_attack,
    output logic               o_defend,
    output logic [2:0]         o_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CHASE   = 3'd1,
        S_RETREAT = 3'd2,
        S_SHOOT   = 3'd3,
        S_DODGE   = 3'd4,
        S_GUARD   = 3'd5
    } state_t;

    // One bit per button-equivalent command.
    typedef struct packed {
        logic right;
        logic left;
        logic jump;
        logic squat;
        logic attack;
        logic defend;
    } cmd_t;

    // Thresholds resized once so every comparison below is width-matched.
    localparam logic [11:0] NEAR_LIM        = 12'(NEAR_DIST);
    localparam logic [11:0] FAR_LIM         = 12'(FAR_DIST);
    localparam logic [11:0] DODGE_LIM       = 12'(DODGE_DIST);
    localparam logic [5:0]  COOLDOWN_RELOAD = 6'(ATK_COOLDOWN);
    localparam logic [5:0]  DODGE_DWELL     = 6'(DODGE_FRAMES - 1);
    localparam logic [5:0]  GUARD_DWELL     = 6'(GUARD_FRAMES - 1);

    state_t     state, state_nxt;
    cmd_t       cmd, cmd_nxt;
    logic [5:0] cooldown, cooldown_nxt;
    logic [5:0] dwell, dwell_nxt;

    // Geometry: differences are taken at 12 bits so the 11-bit signed range cannot wrap.
    logic [11:0] dx;
    logic [11:0] adx;
    logic [11:0] gb_dx;
    logic [11:0] tdist;
    logic        dx_neg;
    logic        dx_zero;
    logic        threat;
    logic        in_dwell;
    logic        can_fire;

    // Only i_rnd[0] steers decisions; the upper bits are reserved for future tie-breaks.
    logic rnd_unused;
    assign rnd_unused = ^i_rnd[3:1];

    assign dx      = {i_player_x[10], i_player_x} - {i_enemy_x[10], i_enemy_x};
    assign gb_dx   = {i_gb_x[10], i_gb_x} - {i_enemy_x[10], i_enemy_x};
    assign dx_neg  = dx[11];
    assign dx_zero = (dx == 12'd0);
    assign adx     = dx_neg ? (~dx + 12'd1) : dx;
    assign tdist   = gb_dx[11] ? (~gb_dx + 12'd1) : gb_dx;
    assign threat  = i_gb_active && (tdist <= DODGE_LIM);

    // A dwell state still counting down ignores every input, threats included.
    assign in_dwell = ((state == S_DODGE) || (state == S_GUARD)) && (dwell != 6'd0);
    assign can_fire = (cooldown == 6'd0) && !i_bb_busy;

    // Next state, counters and next commands; the outputs follow the state being entered.
    always_comb begin
        // NOTE: every variable written here is given a default first, so no path leaves
        // one unassigned and no latch is inferred.
        state_nxt    = state;
        cmd_nxt      = cmd;
        cooldown_nxt = cooldown;
        dwell_nxt    = dwell;

        if (!i_enable) begin
            // Gated off: return to idle with everything cleared, tick or not.
            state_nxt    = S_IDLE;
            cmd_nxt      = '0;
            cooldown_nxt = '0;
            dwell_nxt    = '0;
        end else if (i_tick) begin
            cmd_nxt = '0;

            // Cooldown runs down once per frame outside idle and stops at zero;
            // a shot fired below overrides this with a reload.
            if ((state != S_IDLE) && (cooldown != 6'd0)) begin
                cooldown_nxt = cooldown - 6'd1;
            end

            if (in_dwell) begin
                // Hold the dwell state; jump only on entry, defend on every frame.
                dwell_nxt      = dwell - 6'd1;
                cmd_nxt.defend = (state == S_GUARD);
            end else begin
                // Idle passes straight through chase into the same decision.
                dwell_nxt = '0;
                if (threat) begin
                    if (i_rnd[0]) begin
                        state_nxt    = S_DODGE;
                        dwell_nxt    = DODGE_DWELL;
                        cmd_nxt.jump = 1'b1;
                    end else begin
                        state_nxt      = S_GUARD;
                        dwell_nxt      = GUARD_DWELL;
                        cmd_nxt.defend = 1'b1;
                    end
                end else if (adx > FAR_LIM) begin
                    state_nxt     = S_CHASE;
                    cmd_nxt.right = !dx_neg && !dx_zero;
                    cmd_nxt.left  = dx_neg;
                end else if (adx < NEAR_LIM) begin
                    state_nxt     = S_RETREAT;
                    cmd_nxt.right = dx_neg;
                    cmd_nxt.left  = !dx_neg;
                end else begin
                    state_nxt     = S_SHOOT;
                    cmd_nxt.squat = i_player_squat;
                    if (can_fire) begin
                        cmd_nxt.attack = 1'b1;
                        cooldown_nxt   = COOLDOWN_RELOAD;
                    end
                end
            end
        end
    end

    // State, counters and command register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cmd      <= '0;
            cooldown <= '0;
            dwell    <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register update from the values
            // of the previous cycle, independent of statement order.
            state    <= state_nxt;
            cmd      <= cmd_nxt;
            cooldown <= cooldown_nxt;
            dwell    <= dwell_nxt;
        end
    end

    assign o_right  = cmd.right;
    assign o_left   = cmd.left;
    assign o_jump   = cmd.jump;
    assign o_squat  = cmd.squat;
    assign o_attack = cmd.attack;
    assign o_defend = cmd.defend;
    assign o_state  = state;

endmodule

// File: tb/tb_enemy_ai_ctrl.sv
// tb_enemy_ai_ctrl: directed, scoreboard-checked bench for enemy_ai_ctrl.
// Each step pushes the expected state/commands, then pops and compares them one
// time unit after the clock edge that produces them.
module tb_enemy_ai_ctrl;

    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_R    = 6'b100000;
    localparam logic [5:0] C_L    = 6'b010000;
    localparam logic [5:0] C_J    = 6'b001000;
    localparam logic [5:0] C_SQ   = 6'b000100;
    localparam logic [5:0] C_A    = 6'b000010;
    localparam logic [5:0] C_D    = 6'b000001;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CHASE   = 3'd1;
    localparam logic [2:0] ST_RETREAT = 3'd2;
    localparam logic [2:0] ST_SHOOT   = 3'd3;
    localparam logic [2:0] ST_DODGE   = 3'd4;
    localparam logic [2:0] ST_GUARD   = 3'd5;

    typedef struct {
        string      tag;
        logic [2:0] st;
        logic [5:0] cmd;
    } exp_t;

    logic               clk;
    logic               rst_n;
    logic               i_enable;
    logic               i_tick;
    logic signed [10:0] i_player_x;
    logic               i_player_squat;
    logic signed [10:0] i_enemy_x;
    logic               i_gb_active;
    logic signed [10:0] i_gb_x;
    logic               i_bb_busy;
    logic [3:0]         i_rnd;
    logic               o_right;
    logic               o_left;
    logic               o_jump;
    logic               o_squat;
    logic               o_attack;
    logic               o_defend;
    logic [2:0]         o_state;

    exp_t sb_q[$];
    int   cmp_cnt  = 0;
    int   fail_cnt = 0;

    enemy_ai_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_enable       (i_enable),
        .i_tick         (i_tick),
        .i_player_x     (i_player_x),
        .i_player_squat (i_player_squat),
        .i_enemy_x      (i_enemy_x),
        .i_gb_active    (i_gb_active),
        .i_gb_x         (i_gb_x),
        .i_bb_busy      (i_bb_busy),
        .i_rnd          (i_rnd),
        .o_right        (o_right),
        .o_left         (o_left),
        .o_jump         (o_jump),
        .o_squat        (o_squat),
        .o_attack       (o_attack),
        .o_defend       (o_defend),
        .o_state        (o_state)
    );

    // 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Queue the result the DUT must produce for the step being driven.
    task automatic expect_out(input string tag, input logic [2:0] st, input logic [5:0] cmd);
        exp_t e;
        e.tag = tag;
        e.st  = st;
        e.cmd = cmd;
        sb_q.push_back(e);
    endtask

    // Pop the oldest expectation and compare it with the DUT outputs.
    task automatic check();
        exp_t       e;
        logic [8:0] obs;
        cmp_cnt++;
        if (sb_q.size() == 0) begin
            fail_cnt++;
            $error("FAIL scoreboard_empty: observed nothing queued, required one entry");
            return;
        end
        e   = sb_q.pop_front();
        obs = {o_state, o_right, o_left, o_jump, o_squat, o_attack, o_defend};
        assert (obs === {e.st, e.cmd}) else begin
            fail_cnt++;
            $error("FAIL %s: observed state=%0d cmd=%06b, required state=%0d cmd=%06b",
                   e.tag, obs[8:6], obs[5:0], e.st, e.cmd);
        end
    endtask

    // One frame: tick high across a rising edge, outputs checked just after it.
    task automatic tick_frame(input string tag, input logic [2:0] st, input logic [5:0] cmd);
        @(negedge clk);
        i_tick = 1'b1;
        expect_out(tag, st, cmd);
        @(posedge clk);
        #1;
        i_tick = 1'b0;
        check();
    endtask

    // One clock without a tick.
    task automatic quiet_cycle(input string tag, input logic [2:0] st, input logic [5:0] cmd);
        @(negedge clk);
        i_tick = 1'b0;
        expect_out(tag, st, cmd);
        @(posedge clk);
        #1;
        check();
    endtask

    task automatic set_pos(input int px, input int ex);
        i_player_x = 11'(px);
        i_enemy_x  = 11'(ex);
    endtask

    // Hard time limit so the bench can never hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // Directed sequence.
    initial begin
        rst_n          = 1'b0;
        i_enable       = 1'b0;
        i_tick         = 1'b0;
        i_player_squat = 1'b0;
        i_gb_active    = 1'b0;
        i_gb_x         = '0;
        i_bb_busy      = 1'b0;
        i_rnd          = 4'd0;
        set_pos(500, 0);

        #12;
        expect_out("reset_state", ST_IDLE, C_NONE);
        check();
        @(negedge clk);
        rst_n = 1'b1;

        // Gating: ticks with enable low keep everything idle.
        for (int t = 0; t < 10; t++) begin
            tick_frame($sformatf("gated_%0d", t), ST_IDLE, C_NONE);
        end

        // Distance bands.
        i_enable = 1'b1;
        set_pos(400, 0);
        tick_frame("chase_right", ST_CHASE, C_R);
        quiet_cycle("hold_no_tick", ST_CHASE, C_R);
        set_pos(-400, 0);
        tick_frame("chase_left", ST_CHASE, C_L);
        set_pos(100, 0);
        tick_frame("retreat_pos", ST_RETREAT, C_L);
        set_pos(-100, 0);
        tick_frame("retreat_neg", ST_RETREAT, C_R);
        set_pos(0, 0);
        tick_frame("retreat_zero", ST_RETREAT, C_L);

        // Shoot band with the bad bullet busy, so cooldown stays at zero.
        i_bb_busy = 1'b1;
        set_pos(200, 0);
        tick_frame("shoot_band", ST_SHOOT, C_NONE);
        i_player_squat = 1'b1;
        tick_frame("shoot_squat", ST_SHOOT, C_SQ);
        i_player_squat = 1'b0;
        set_pos(160, 0);
        tick_frame("near_edge_160", ST_SHOOT, C_NONE);
        set_pos(159, 0);
        tick_frame("near_edge_159", ST_RETREAT, C_L);
        set_pos(320, 0);
        tick_frame("far_edge_320", ST_SHOOT, C_NONE);
        set_pos(-320, 0);
        tick_frame("far_edge_neg320", ST_SHOOT, C_NONE);
        set_pos(321, 0);
        tick_frame("far_edge_321", ST_CHASE, C_R);
        set_pos(-21, 300);
        tick_frame("chase_offset_enemy", ST_CHASE, C_L);

        // Shot cadence: attacks every ATK_COOLDOWN+1 ticks.
        i_bb_busy = 1'b0;
        set_pos(200, 0);
        for (int t = 1; t <= 93; t++) begin
            tick_frame($sformatf("cadence_%0d", t), ST_SHOOT,
                       (t == 1 || t == 32 || t == 63) ? C_A : C_NONE);
        end
        i_bb_busy = 1'b1;
        for (int t = 0; t < 5; t++) begin
            tick_frame($sformatf("busy_block_%0d", t), ST_SHOOT, C_NONE);
        end
        i_bb_busy = 1'b0;
        tick_frame("busy_release_fire", ST_SHOOT, C_A);
        tick_frame("after_release", ST_SHOOT, C_NONE);

        // Dodge: jump on entry only, state held 8 frames although threat clears.
        i_gb_active = 1'b1;
        i_gb_x      = 11'sd50;
        i_rnd       = 4'b0001;
        tick_frame("dodge_entry", ST_DODGE, C_J);
        i_gb_active = 1'b0;
        for (int t = 2; t <= 8; t++) begin
            tick_frame($sformatf("dodge_frame_%0d", t), ST_DODGE, C_NONE);
        end
        tick_frame("dodge_exit", ST_SHOOT, C_NONE);
        i_gb_active = 1'b1;
        i_gb_x      = 11'sd97;
        i_rnd       = 4'b0000;
        tick_frame("threat_edge_97", ST_SHOOT, C_NONE);

        // Guard at the threat edge; a threat mid-dwell is ignored.
        i_gb_x = -11'sd96;
        i_rnd  = 4'b1110;
        tick_frame("guard_entry_96", ST_GUARD, C_D);
        i_rnd = 4'b0001;
        for (int t = 2; t <= 12; t++) begin
            tick_frame($sformatf("guard_frame_%0d", t), ST_GUARD, C_D);
        end
        i_gb_active = 1'b0;
        tick_frame("guard_exit_shoot", ST_SHOOT, C_NONE);

        // Abort: enable drops mid-guard without a tick.
        i_gb_active = 1'b1;
        i_rnd       = 4'b0000;
        tick_frame("abort_guard_1", ST_GUARD, C_D);
        for (int t = 2; t <= 5; t++) begin
            tick_frame($sformatf("abort_guard_%0d", t), ST_GUARD, C_D);
        end
        i_enable = 1'b0;
        quiet_cycle("enable_drop", ST_IDLE, C_NONE);
        tick_frame("enable_low_tick", ST_IDLE, C_NONE);

        // Re-enable: cooldown was cleared, so the first shoot frame fires.
        i_enable    = 1'b1;
        i_gb_active = 1'b0;
        tick_frame("reenable_fire", ST_SHOOT, C_A);
        tick_frame("reenable_cool", ST_SHOOT, C_NONE);

        // Asynchronous reset mid-shoot clears outputs without a clock edge.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("async_reset", ST_IDLE, C_NONE);
        check();
        @(negedge clk);
        rst_n = 1'b1;
        quiet_cycle("post_reset_hold", ST_IDLE, C_NONE);
        tick_frame("post_reset_fire", ST_SHOOT, C_A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/enemy_ai_ctrl.md
# enemy_ai_ctrl

Frame-rate behaviour controller that produces the enemy's button-equivalent commands (right/left/jump/squat/attack/defend) for the enemy character and bad-bullet blocks. It replaces free-running pseudo-random enemy input with a decision state machine. Decisions depend on player–enemy distance, incoming good-bullet threat, an attack cooldown and random tie-break bits. It sits beside the game controller and is gated by the "gaming" status.

## Interface
- NEAR_DIST, 160: horizontal distance (px) below which the enemy retreats.
- FAR_DIST, 320: horizontal distance (px) above which the enemy chases.
- DODGE_DIST, 96: good-bullet-to-enemy horizontal distance (px) that counts as a threat.
- ATK_COOLDOWN, 30: frames between shots (6-bit max 63).
- DODGE_FRAMES, 8: dwell in DODGE (frames, 1..63).
- GUARD_FRAMES, 12: dwell in GUARD (frames, 1..63).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- i_enable  in  1  high while game in play state
- i_tick  in  1  one-cycle frame pulse; all decisions occur on cycles with i_tick=1
- i_player_x  in  11 signed  player x
- i_player_squat  in  1  player squatting
- i_enemy_x  in  11 signed  enemy x
- i_gb_active  in  1  good bullet in flight
- i_gb_x  in  11 signed  good bullet x
- i_bb_busy  in  1  bad bullet already in flight
- i_rnd  in  4  random bits (any source), sampled on tick
- o_right, o_left, o_jump, o_squat, o_attack, o_defend  out  1 each  registered enemy commands
- o_state  out  3  current state encoding (debug)

## Operation
- States and encodings: S_IDLE=0, S_CHASE=1, S_RETREAT=2, S_SHOOT=3, S_DODGE=4, S_GUARD=5.
- dx = i_player_x − i_enemy_x, sign-extended to 12 bits. adx = |dx| as 12-bit unsigned. tdist = |i_gb_x − i_enemy_x| as 12-bit unsigned.
- threat = i_gb_active && tdist <= DODGE_DIST.
- i_enable=0 (any cycle, tick or not): next state S_IDLE, all outputs 0, cooldown=0, dwell=0. Takes priority over everything except reset.
- S_IDLE with i_enable=1 and i_tick=1: go to S_CHASE, then evaluate per the decision rule in the same tick.
- Dwell states (DODGE, GUARD): on a tick with dwell>0, decrement dwell and hold the state. On a tick with dwell==0, evaluate the decision rule.
- CHASE, RETREAT and SHOOT evaluate the decision rule on every tick.
- Decision rule, in priority order:
  - (1) threat: if i_rnd[0]=1, go to DODGE with dwell=DODGE_FRAMES−1; otherwise go to GUARD with dwell=GUARD_FRAMES−1.
  - (2) adx > FAR_DIST: go to CHASE.
  - (3) adx < NEAR_DIST: go to RETREAT.
  - (4) otherwise: go to SHOOT.
- Outputs are registered and computed from the next state on the tick. They are held constant until the next tick.
  - CHASE: o_right = (dx>0), o_left = (dx<0). If dx==0, both are 0.
  - RETREAT: o_right = (dx<0), o_left = (dx>=0).
  - SHOOT: no movement. o_squat = i_player_squat. o_attack=1 for this frame only if cooldown==0 and i_bb_busy=0; that shot reloads cooldown to ATK_COOLDOWN.
  - DODGE: o_jump=1 on the entry frame only, 0 on the remaining dwell frames. No other outputs.
  - GUARD: o_defend=1 for every frame of the dwell. No other outputs.
- o_right and o_left are never both 1. o_attack and o_defend are never both 1.
- Cooldown decrements on every tick in non-IDLE states and saturates at 0. It is not decremented on the tick that fires an attack.

## Timing
- Reset values: state S_IDLE, all outputs 0, o_state=0, cooldown=0, dwell=0.
- Latency: the inputs on the i_tick cycle determine the outputs visible on the following cycle (one register stage).
- Outputs and state change only on tick cycles, except the synchronous forced return to IDLE on i_enable=0.
- An i_tick asserted in consecutive cycles is treated as consecutive frames.
- A threat arriving mid-dwell is ignored until dwell reaches 0.
- Attack period under continuous SHOOT with i_bb_busy=0 is ATK_COOLDOWN+1 ticks.
- Reset asserted mid-operation immediately clears all state, asynchronously.

## Test plan
- Gating: i_enable=0, 10 ticks with player far away → all outputs 0, o_state=0. Raise i_enable, one tick with dx=+400 → next cycle o_state=1, o_right=1.
- Distance bands: dx=−400 → o_left=1 (CHASE). dx=+100 → o_left=1 (RETREAT). dx=+200 → o_state=3, no movement.
- Shot cadence: hold dx=200, i_bb_busy=0, 70 ticks → o_attack=1 on ticks 1, 32 and 63 only. Then hold i_bb_busy=1 at a cooldown of 0 → no attack until busy drops, and attack fires on the first tick after it drops.
- Dodge: i_gb_active=1, tdist=50, i_rnd[0]=1 → o_state=4, o_jump=1 for one frame, and the state is held for exactly 8 ticks even if the threat clears.
- Guard: same stimulus with i_rnd[0]=0 → o_defend=1 for 12 ticks. Then with the threat clear and dx=200 → SHOOT.
- Abort: drop i_enable at guard frame 5 with no tick → next cycle o_defend=0, o_state=0. Assert rst_n=0 mid-SHOOT → outputs 0 immediately.
